// File: rtl/usb_rx_decoder.sv
// USB receive front end: NRZI decode, SYNC hunt, bit unstuffing, EOP detect.
// Emits the unstuffed serial stream (PID first, LSB first) with framing pulses.
module usb_rx_decoder #(
    parameter int MAX_PKT_BITS = 88,
    parameter int STUFF_LEN    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       dp_in,
    input  logic       dm_in,
    output logic       rx_active,
    output logic       pkt_start,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       eop,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

    localparam logic [6:0] MAX_BITS = 7'(MAX_PKT_BITS);
    localparam logic [2:0] STUFF    = 3'(STUFF_LEN);
    localparam logic [1:0] E_STUFF  = 2'b01;
    localparam logic [1:0] E_LINE   = 2'b10;
    localparam logic [1:0] E_LEN    = 2'b11;

    state_t     state, state_d;
    logic       prev_level, prev_d;
    logic [2:0] sync_cnt, sync_d;
    logic [2:0] ones_cnt, ones_d;
    logic [6:0] bit_cnt, bit_d;
    logic [1:0] se0_cnt, se0_d;

    logic       ev_start, ev_bit, ev_eop, ev_err;
    logic [1:0] ev_code;
    logic       act_d, out_d;
    logic [1:0] code_d;

    logic line_j, line_k, line_se0, line_jk, dec;

    assign line_j   = dp_in & ~dm_in;
    assign line_k   = ~dp_in & dm_in;
    assign line_se0 = ~dp_in & ~dm_in;
    assign line_jk  = line_j | line_k;
    // prev_level holds dp of the last J/K sample, so equal dp means a decoded 1
    assign dec      = (dp_in == prev_level);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prev_level <= 1'b1;
            sync_cnt   <= '0;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            se0_cnt    <= '0;
        end else begin
            state      <= state_d;
            prev_level <= prev_d;
            sync_cnt   <= sync_d;
            ones_cnt   <= ones_d;
            bit_cnt    <= bit_d;
            se0_cnt    <= se0_d;
        end
    end

    always_comb begin
        state_d  = state;
        prev_d   = prev_level;
        sync_d   = sync_cnt;
        ones_d   = ones_cnt;
        bit_d    = bit_cnt;
        se0_d    = se0_cnt;
        ev_start = 1'b0;
        ev_bit   = 1'b0;
        ev_eop   = 1'b0;
        ev_err   = 1'b0;
        ev_code  = 2'b00;
        if (!rx_en) begin
            state_d = IDLE;
            prev_d  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (line_k) begin
                        state_d = SYNC;
                        sync_d  = 3'd1;
                        prev_d  = 1'b0;
                    end else begin
                        prev_d = 1'b1;
                    end
                end
                SYNC: begin
                    if (!line_jk || (dec != (sync_cnt == 3'd7))) begin
                        state_d = IDLE;
                        prev_d  = 1'b1;
                    end else if (sync_cnt == 3'd7) begin
                        state_d  = DATA;
                        ev_start = 1'b1;
                        ones_d   = 3'd1;
                        bit_d    = '0;
                        prev_d   = dp_in;
                    end else begin
                        sync_d = sync_cnt + 3'd1;
                        prev_d = dp_in;
                    end
                end
                DATA: begin
                    if (line_jk) begin
                        prev_d = dp_in;
                        if (ones_cnt == STUFF) begin
                            if (!dec) begin
                                ones_d = '0;
                            end else begin
                                ev_err  = 1'b1;
                                ev_code = E_STUFF;
                                state_d = IDLE;
                                prev_d  = 1'b1;
                            end
                        end else if (bit_cnt == MAX_BITS) begin
                            ev_err  = 1'b1;
                            ev_code = E_LEN;
                            state_d = IDLE;
                            prev_d  = 1'b1;
                        end else begin
                            ev_bit = 1'b1;
                            bit_d  = bit_cnt + 7'd1;
                            ones_d = dec ? ones_cnt + 3'd1 : 3'd0;
                        end
                    end else if (line_se0) begin
                        state_d = EOP;
                        se0_d   = 2'd1;
                    end else begin
                        ev_err  = 1'b1;
                        ev_code = E_LINE;
                        state_d = IDLE;
                        prev_d  = 1'b1;
                    end
                end
                EOP: begin
                    if (line_se0) begin
                        se0_d = (se0_cnt == 2'd3) ? 2'd3 : se0_cnt + 2'd1;
                    end else if (line_j && se0_cnt >= 2'd2) begin
                        ev_eop  = 1'b1;
                        state_d = IDLE;
                        prev_d  = 1'b1;
                    end else begin
                        ev_err  = 1'b1;
                        ev_code = E_LINE;
                        state_d = IDLE;
                        prev_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    prev_d  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        act_d  = (state_d == DATA) || (state_d == EOP);
        out_d  = ev_bit & dec;
        code_d = ev_err ? ev_code : err_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_active <= 1'b0;
            pkt_start <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            eop       <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            rx_active <= act_d;
            pkt_start <= ev_start;
            bit_out   <= out_d;
            bit_valid <= ev_bit;
            eop       <= ev_eop;
            err       <= ev_err;
            err_code  <= code_d;
        end
    end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: NRZI line driver with an event scoreboard,
// a packet table plus hand-written overflow, reset and enable sequences.
module tb_usb_rx_decoder;

    logic       clk = 1'b0;
    logic       rst, rx_en, dp_in, dm_in;
    logic       rx_active, pkt_start, bit_out, bit_valid, eop, err;
    logic [1:0] err_code;

    usb_rx_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .rx_en     (rx_en),
        .dp_in     (dp_in),
        .dm_in     (dm_in),
        .rx_active (rx_active),
        .pkt_start (pkt_start),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .eop       (eop),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    localparam int T_START = 1;
    localparam int T_BIT   = 2;
    localparam int T_EOP   = 3;
    localparam int T_ERR   = 4;

    typedef struct {
        int         kind;
        logic       val;
        logic [1:0] code;
        logic       act;
        int         at;
    } tok_t;

    // wire_bits: decoded bits after SYNC, LSB first; emit: which give bit_valid
    // term: 0 EOP, 1 short SE0, 2 SE1, 3 in-band error, 4 long EOP
    typedef struct {
        string       name;
        int          n;
        logic [15:0] wire_bits;
        logic [15:0] emit;
        int          term;
        logic [1:0]  code;
    } vec_t;

    tok_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   samp = 0;
    int   n_start = 0;
    int   n_err = 0;
    logic cur = 1'b1;

    task automatic push(int kind, logic val, logic [1:0] code);
        tok_t t;
        t.kind = kind;
        t.val  = val;
        t.code = code;
        t.act  = (kind == T_START) || (kind == T_BIT);
        t.at   = samp;
        q.push_back(t);
    endtask

    task automatic check();
        tok_t e;
        int   np;
        int   got;
        logic ok;
        np = int'(pkt_start) + int'(bit_valid) + int'(eop) + int'(err);
        n_start += int'(pkt_start);
        n_err   += int'(err);
        got = pkt_start ? T_START : bit_valid ? T_BIT :
              eop ? T_EOP : err ? T_ERR : 0;
        while (q.size() > 0 && q[0].at < samp) begin
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing event kind=%0d due@%0d", e.kind, e.at);
        end
        if (q.size() > 0 && q[0].at == samp) begin
            e = q.pop_front();
            vectors++;
            ok = (np == 1) && (got == e.kind) && (rx_active == e.act) &&
                 (e.kind != T_BIT || bit_out == e.val) &&
                 (e.kind != T_ERR || err_code == e.code);
            if (!ok) begin
                miscompares++;
                $display("FAIL event@%0d got kind=%0d n=%0d bit=%b code=%b act=%b want kind=%0d bit=%b code=%b act=%b",
                         samp, got, np, bit_out, err_code, rx_active,
                         e.kind, e.val, e.code, e.act);
            end
        end else if (np != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected@%0d got kind=%0d n=%0d want none",
                     samp, got, np);
        end
    endtask

    task automatic drive(logic dp, logic dm);
        dp_in = dp;
        dm_in = dm;
        @(posedge clk);
        #1;
        check();
        samp++;
    endtask

    task automatic tx_bit(logic d);
        if (!d) cur = ~cur;
        drive(cur, ~cur);
    endtask

    task automatic idle(int n);
        cur = 1'b1;
        repeat (n) drive(1'b1, 1'b0);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) tx_bit(1'b0);
        push(T_START, 1'b0, 2'b00);
        tx_bit(1'b1);
    endtask

    task automatic flush(string name);
        tok_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s never saw kind=%0d due@%0d", name, e.kind, e.at);
        end
    endtask

    task automatic run_vec(vec_t v);
        idle(3);
        send_sync();
        for (int i = 0; i < v.n; i++) begin
            if (v.emit[i]) push(T_BIT, v.wire_bits[i], 2'b00);
            if (v.term == 3 && i == v.n - 1) push(T_ERR, 1'b0, v.code);
            tx_bit(v.wire_bits[i]);
        end
        case (v.term)
            0: begin
                drive(1'b0, 1'b0);
                drive(1'b0, 1'b0);
                push(T_EOP, 1'b0, 2'b00);
                drive(1'b1, 1'b0);
            end
            1: begin
                drive(1'b0, 1'b0);
                push(T_ERR, 1'b0, v.code);
                drive(1'b1, 1'b0);
            end
            2: begin
                push(T_ERR, 1'b0, v.code);
                drive(1'b1, 1'b1);
            end
            4: begin
                repeat (4) drive(1'b0, 1'b0);
                push(T_EOP, 1'b0, 2'b00);
                drive(1'b1, 1'b0);
            end
            default: ;
        endcase
        idle(2);
        flush(v.name);
    endtask

    vec_t tbl[7];
    int   s0, e0;

    initial begin
        tbl[0] = '{"ack",        8,  16'h00D2, 16'h00FF, 0, 2'b00};
        tbl[1] = '{"stuff_ok",   8,  16'h005F, 16'h00DF, 0, 2'b00};
        tbl[2] = '{"stuff_err",  6,  16'h003F, 16'h001F, 3, 2'b01};
        tbl[3] = '{"short_se0",  8,  16'h00D2, 16'h00FF, 1, 2'b10};
        tbl[4] = '{"se1_mid",    4,  16'h0002, 16'h000F, 2, 2'b10};
        tbl[5] = '{"long_eop",   16, 16'h00C3, 16'hFFFF, 4, 2'b00};
        tbl[6] = '{"sync_stuff", 8,  16'h009F, 16'h00DF, 0, 2'b00};

        rst   = 1'b1;
        rx_en = 1'b1;
        dp_in = 1'b1;
        dm_in = 1'b0;
        #12;
        vectors++;
        if ({rx_active, pkt_start, bit_out, bit_valid, eop, err, err_code} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state got %b want 00000000",
                     {rx_active, pkt_start, bit_out, bit_valid, eop, err, err_code});
        end
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // 89 data bits: the last one overflows the length limit
        idle(3);
        send_sync();
        for (int i = 0; i < 88; i++) begin
            push(T_BIT, 1'b0, 2'b00);
            tx_bit(1'b0);
        end
        push(T_ERR, 1'b0, 2'b11);
        tx_bit(1'b0);
        idle(2);
        flush("overflow");
        run_vec(tbl[0]);
        vectors++;
        if (err_code !== 2'b11) begin
            miscompares++;
            $display("FAIL err_code_held got %b want 11", err_code);
        end

        // async reset mid-packet
        idle(3);
        send_sync();
        push(T_BIT, 1'b1, 2'b00);
        tx_bit(1'b1);
        push(T_BIT, 1'b0, 2'b00);
        tx_bit(1'b0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({rx_active, pkt_start, bit_out, bit_valid, eop, err, err_code} !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_mid got %b want 00000000",
                     {rx_active, pkt_start, bit_out, bit_valid, eop, err, err_code});
        end
        tx_bit(1'b1);
        #2 rst = 1'b0;
        run_vec(tbl[0]);

        // corrupted SYNC: K J K K J K J K K
        s0 = n_start;
        e0 = n_err;
        idle(3);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        idle(4);
        vectors++;
        if (n_start != s0) begin
            miscompares++;
            $display("FAIL bad_sync_start got %0d want 0", n_start - s0);
        end
        vectors++;
        if (n_err != e0) begin
            miscompares++;
            $display("FAIL bad_sync_err got %0d want 0", n_err - e0);
        end

        // receiver disabled mid-DATA
        e0 = n_err;
        idle(3);
        send_sync();
        push(T_BIT, 1'b1, 2'b00);
        tx_bit(1'b1);
        push(T_BIT, 1'b0, 2'b00);
        tx_bit(1'b0);
        rx_en = 1'b0;
        tx_bit(1'b1);
        vectors++;
        if ({rx_active, pkt_start, bit_out, bit_valid, eop, err} !== 6'h00) begin
            miscompares++;
            $display("FAIL rx_en_off got %b want 000000",
                     {rx_active, pkt_start, bit_out, bit_valid, eop, err});
        end
        tx_bit(1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        vectors++;
        if (n_err != e0) begin
            miscompares++;
            $display("FAIL rx_en_off_err got %0d want 0", n_err - e0);
        end
        rx_en = 1'b1;
        run_vec(tbl[0]);
        flush("final");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_rx_decoder.md
Name: usb_rx_decoder

Overview:
- Receive-side front end of the USB link; mirror of the transmit chain (bit stream encoder -> bit stuffer -> NRZI -> DP/DM driver).
- Samples DP/DM once per clk and decodes NRZI.
- Hunts for SYNC, strips stuffed bits and detects EOP.
- Delivers a qualified serial bit stream (PID first, LSB-first, as on the wire) to the downstream packet decoder, with start, end and error indications.

Parameters:
- MAX_PKT_BITS, 88, max unstuffed bits after SYNC (PID 8 + DATA 64 + CRC16 16); exceeding it is a length error.
- STUFF_LEN, 6, consecutive decoded 1s after which a stuffed 0 is expected.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- rx_en  input  1  receiver enable; low while the local transmitter owns the bus
- dp_in  input  1  sampled D+ level
- dm_in  input  1  sampled D- level
- rx_active  output  1  high from SYNC match until EOP or abort
- pkt_start  output  1  1-cycle pulse on the cycle the SYNC match completes
- bit_out  output  1  decoded, unstuffed data bit
- bit_valid  output  1  bit_out qualifier
- eop  output  1  1-cycle pulse, valid EOP received
- err  output  1  1-cycle pulse, packet aborted
- err_code  output  2  01 stuff error, 10 line error (SE1 / short SE0), 11 length overflow; held until next err or reset

Behaviour:
- Line states:
  - J = (dp,dm)=10
  - K = 01
  - SE0 = 00
  - SE1 = 11
- NRZI decode: decoded bit = 1 if the J/K level equals the previous J/K level, 0 if it changed. prev_level resets to J and is reloaded to J on every entry to IDLE.
- All outputs are registered, with 1-cycle latency from the sampling posedge of dp_in/dm_in.
- Reset values: all outputs 0, err_code 00, state IDLE, all counters 0.
- rx_en=0: state is forced to IDLE on the next edge, rx_active=0, no pulses. A packet in flight is dropped silently (no err).
- FSM IDLE:
  - Stay while the line is J or SE0.
  - K -> SYNC, with sync_cnt=1; the first decoded bit is 0.
- FSM SYNC:
  - Expected decoded pattern: 0000000 then 1 (KJKJKJKK).
  - Any mismatch or non-J/K level -> IDLE silently.
  - On the 8th bit matching: -> DATA, pkt_start=1, rx_active=1, ones_cnt=1 (the SYNC final 1 counts toward stuffing), bit_cnt=0.
- FSM DATA, J/K samples:
  - Each decoded bit updates ones_cnt: +1 on a 1, cleared on a 0.
  - If ones_cnt==STUFF_LEN before this bit:
    - decoded 0: stuffed bit, dropped (bit_valid=0), ones_cnt=0.
    - decoded 1: err, err_code=01, -> IDLE.
  - Otherwise: bit_valid=1, bit_out=decoded bit, bit_cnt+1.
  - A valid bit with bit_cnt already == MAX_PKT_BITS: err, err_code=11, -> IDLE; that bit is not emitted.
- FSM DATA, other samples:
  - SE0 -> EOP, with se0_cnt=1.
  - SE1 -> err, err_code=10, -> IDLE.
- FSM EOP:
  - SE0: se0_cnt+1, saturating at 3.
  - J with se0_cnt>=2: eop=1, rx_active=0, -> IDLE.
  - J with se0_cnt==1, or K or SE1: err, err_code=10, -> IDLE.
- rx_active drops on the same cycle as eop or err.
- pkt_start, bit_valid, eop and err are never asserted together.
- No bit_valid is asserted outside DATA.
- bit_cnt is 7 bits; the overflow check above ensures it never wraps.
- Reset mid-packet: all outputs return to 0 asynchronously; no eop or err is issued.

Test Plan:
- Idle J for 5 cycles, then SYNC, ACK (wire order 0,1,0,0,1,0,1,1), then SE0,SE0,J -> pkt_start once; exactly 8 bit_valid pulses carrying 01001011; eop 1 cycle after the J sample; err never asserted.
- SYNC then decoded payload 1,1,1,1,1,0(stuffed),1,0, then EOP -> valid bits 1,1,1,1,1,1,0 (6 ones after unstuffing; the stuffed 0 is dropped with bit_valid low that cycle); no err.
- SYNC then decoded 1,1,1,1,1,1 (no stuffed 0) -> 5 valid 1s, then err=1, err_code=01, rx_active=0; no eop.
- SYNC + PID, then a single SE0 followed by J -> err_code=10; a second run with SE1 mid-data -> err_code=10.
- SYNC then 89 valid bits with no EOP -> 88 bit_valid pulses, then err_code=11 and IDLE. A subsequent correct ACK packet decodes cleanly.
- Two further checks:
  - Corrupted SYNC (KJKKJ...) -> no pkt_start or err.
  - rx_en deasserted, or rst pulsed, mid-DATA -> all outputs 0 next cycle; the following packet decodes cleanly.
